psg_write_sched: RTL and testbench
==================================

Name: psg_write_sched

Overview:
- Shares the SN76489-compatible PSG (ti_top) write port between two requesters: A = 68k-side bridge, B = Z80-side bridge.
- Requests are arbitrated round-robin into a small FIFO.
- A sequencer drains the FIFO onto the PSG bus (nCE/nWE/D) and honours the PSG READY handshake.
- Sits between the CPU bus bridges and ti_top in sega_genesis_top, on the PSG clock domain.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- GAP, 2, idle cycles with nCE/nWE high between consecutive writes; >= 1.
- TIMEOUT, 64, maximum assertion cycles waiting for READY before a forced release; >= 4.

Ports:
- CLK  input  1  PSG-domain clock.
- RST  input  1  asynchronous reset, active-high.
- a_valid  input  1  requester A has a byte.
- a_data  input  8  requester A byte.
- a_ready  output  1  A's byte accepted this cycle.
- b_valid  input  1  requester B has a byte.
- b_data  input  8  requester B byte.
- b_ready  output  1  B's byte accepted this cycle.
- psg_nCE  output  1  PSG chip enable, active-low.
- psg_nWE  output  1  PSG write enable, active-low.
- psg_D  output  8  PSG data bus.
- psg_READY  input  1  PSG ready; low while a latch is in progress.
- busy  output  1  FIFO non-empty or sequencer not in IDLE.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- timeout_err  output  1  sticky; set on any forced release.

Behaviour:
- Reset state (asynchronous, RST=1):
  - psg_nCE=1, psg_nWE=1, psg_D=0.
  - a_ready=0, b_ready=0, busy=0, fifo_level=0, timeout_err=0.
  - FIFO empty, FSM in IDLE, round-robin pointer = A.
  - Asserting RST mid-write drops nCE/nWE to 1 immediately and discards all FIFO contents.
- Arbitration (combinational grant, registered push):
  - Grant only when the FIFO is not full at the start of the cycle. No bypass: a same-cycle pop does not free space for a push.
  - Only one side valid: that side is granted.
  - Both valid: the side named by the pointer is granted; the pointer then moves to the other side.
  - x_ready = grant_x. A handshake completes when x_valid && x_ready; the byte is written to the FIFO at that clock edge.
  - fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
- Sequencer FSM:
  - IDLE: if FIFO non-empty, pop the head into the psg_D register and go to ASSERT.
  - ASSERT (1 cycle): nCE=0, nWE=0, D held; go to WAIT. The cycle counter starts at 1.
  - WAIT: nCE=nWE=0, D held, counter increments each cycle.
    - psg_READY=1 sampled with counter >= 2 → RELEASE.
    - counter == TIMEOUT → RELEASE and set timeout_err.
  - RELEASE: nCE=nWE=1 for GAP cycles (D held), then IDLE.
- Latency and throughput:
  - Minimum latency from accepted request to nCE falling: 2 cycles (push, then pop in IDLE, then ASSERT).
  - Back-to-back writes: one write per (3 + GAP) cycles at minimum.
- timeout_err clears only on RST.
- FIFO pointers wrap modulo DEPTH. Full means level == DEPTH; empty means level == 0.

Optional Feature:
- Macro: PSG_MUTE_INIT_EN.
- Defined:
  - After RST deasserts, the sequencer first issues four writes from the package constant array: 8'h9F, 8'hBF, 8'hDF, 8'hFF (attenuation = off on channels 0-3).
  - These use the normal ASSERT/WAIT/RELEASE timing.
  - a_ready and b_ready are held 0 and busy=1 until the fourth write reaches RELEASE end.
- Undefined: no init writes; requesters may be granted in the first cycle after reset.

Decomposition:
- Package sega_psg_pkg:
  - FSM state enum {IDLE, ASSERT, WAIT, RELEASE}.
  - PSG_MUTE_BYTES[4] constant.
  - Latch/attenuation command bit-field constants, shared with future PSG blocks.
- Sub-module psg_wr_fifo: parameterised DEPTH x 8 synchronous FIFO with push, pop, full, empty and level. The arbiter and FSM stay in psg_write_sched.

Test Plan:
- A only: a_valid=1, a_data=8'h8E, psg_READY pulsed high 5 cycles after nCE falls → a_ready=1 for one cycle; nCE/nWE low with D=8'h8E; release one cycle after READY is sampled high; then GAP=2 high cycles; busy falls.
- Both valid every cycle, A bytes 8'h10..8'h13, B bytes 8'h20..8'h23, READY tied 1 → PSG write order 10,20,11,21,12,22,13,23; spacing exactly 5 cycles per write.
- Fill: READY held 0, A pushes 6 bytes → first byte popped into WAIT; fifo_level saturates at 4; a_ready=0 while full; no byte lost or duplicated once READY rises.
- Timeout: READY held 0 → release after exactly 64 assertion cycles; timeout_err=1 and stays 1; the next write proceeds normally.
- Reset mid-WAIT with 3 bytes queued → nCE/nWE=1 in the same cycle; fifo_level=0; after RST falls no stale write appears on the bus.
- With PSG_MUTE_INIT_EN defined: release RST with no requests → writes 9F, BF, DF, FF in order; a_ready=0 throughout; first A byte follows FF.

Source files
------------

// File: rtl/sega_psg_pkg.sv
// Shared PSG definitions: write-sequencer states, SN76489 command bit fields, mute-init bytes.
package sega_psg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } psg_seq_e;

    // SN76489 command byte layout: bit7 latch, bits6:5 channel, bit4 type (1 = attenuation)
    localparam int         PSG_LATCH_BIT = 7;
    localparam int         PSG_CH_LSB    = 5;
    localparam int         PSG_TYPE_BIT  = 4;
    localparam logic [3:0] PSG_ATTN_OFF  = 4'hF;

    function automatic logic [7:0] psg_latch_byte(input logic [1:0] ch, input logic is_attn,
                                                  input logic [3:0] data);
        return {1'b1, ch, is_attn, data};
    endfunction

    // Index 0 is issued first: channels 0..3 attenuation off
    localparam logic [3:0][7:0] PSG_MUTE_BYTES = {8'hFF, 8'hDF, 8'hBF, 8'h9F};

endpackage

// File: rtl/psg_wr_fifo.sv
// DEPTH x 8 synchronous FIFO; pointers wrap modulo DEPTH, level is the registered occupancy.
module psg_wr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/psg_write_sched.sv
// Round-robin A/B arbiter + FIFO + nCE/nWE sequencer for the PSG write port.
// Optional PSG_MUTE_INIT_EN: issue four attenuation-off writes after reset before serving requesters.
module psg_write_sched
    import sega_psg_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   a_valid,
    input  logic [7:0]             a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [7:0]             b_data,
    output logic                   b_ready,
    output logic                   psg_nCE,
    output logic                   psg_nWE,
    output logic [7:0]             psg_D,
    input  logic                   psg_READY,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   timeout_err
);
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    psg_seq_e      state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    d_q, load_data, fifo_head;
    logic          strobe_n, load, pop, set_err, rr_b;
    logic          can_push, init_busy, fifo_full, fifo_empty;

    // Grant decided from start-of-cycle fullness only; no pop bypass
    assign can_push = !RST && !fifo_full && !init_busy;
    assign a_ready  = can_push && a_valid && (!b_valid || !rr_b);
    assign b_ready  = can_push && b_valid && (!a_valid || rr_b);

    psg_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (a_ready || b_ready),
        .push_data (a_ready ? a_data : b_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef PSG_MUTE_INIT_EN
    logic [1:0] init_idx;
    logic       init_done;
    logic [7:0] init_byte;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_idx  <= '0;
            init_done <= 1'b0;
        end else if (!init_done && state == RELEASE && cnt == CW'(GAP)) begin
            if (init_idx == 2'd3) init_done <= 1'b1;
            else                  init_idx  <= init_idx + 2'd1;
        end
    end

    assign init_busy = !init_done;
    assign init_byte = PSG_MUTE_BYTES[init_idx];
`else
    assign init_busy = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        load       = 1'b0;
        load_data  = fifo_head;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (init_busy) begin
`ifdef PSG_MUTE_INIT_EN
                    load_data = init_byte;
`endif
                    load       = 1'b1;
                    state_next = ASSERT;
                    cnt_next   = CW'(1);
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = ASSERT;
                    cnt_next   = CW'(1);
                end
            end
            ASSERT: begin
                state_next = WAIT;
                cnt_next   = cnt + 1'b1;
            end
            WAIT: begin
                // cnt counts cycles with the strobes low, ASSERT included
                if (psg_READY && cnt >= CW'(2)) begin
                    state_next = RELEASE;
                    cnt_next   = CW'(1);
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_next = RELEASE;
                    cnt_next   = CW'(1);
                    set_err    = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt == CW'(GAP)) state_next = IDLE;
                else                 cnt_next   = cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            d_q         <= '0;
            strobe_n    <= 1'b1;
            timeout_err <= 1'b0;
            rr_b        <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            strobe_n <= !(state_next == ASSERT || state_next == WAIT);
            if (load)    d_q         <= load_data;
            if (set_err) timeout_err <= 1'b1;
            if (a_valid && b_valid && can_push) rr_b <= !rr_b;
        end
    end

    assign psg_nCE = strobe_n;
    assign psg_nWE = strobe_n;
    assign psg_D   = d_q;
    assign busy    = !fifo_empty || (state != IDLE) || init_busy;

endmodule

// File: tb/tb_psg_write_sched.sv
// Randomized + directed bench for psg_write_sched against a queue-based behavioural model.
module tb_psg_write_sched;
    localparam int DEPTH = 4, GAP = 2, TIMEOUT = 64;

    logic       CLK = 0, RST = 0;
    logic       a_valid = 0, b_valid = 0, psg_READY = 1;
    logic [7:0] a_data = 0, b_data = 0;
    logic       a_ready, b_ready, psg_nCE, psg_nWE, busy, timeout_err;
    logic [7:0] psg_D;
    logic [2:0] fifo_level;

    psg_write_sched #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .psg_nCE(psg_nCE), .psg_nWE(psg_nWE), .psg_D(psg_D), .psg_READY(psg_READY),
        .busy(busy), .fifo_level(fifo_level), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: queue of pending bytes, one write in flight described by
    // how long the strobes have been low, then a fixed gap.
    byte unsigned q[$], init_q[$];
    bit           m_ptr_b, m_err, m_cur_init, m_init_pend;
    int           m_mode, m_low, m_gap;   // mode 0 = free, 1 = strobes low, 2 = gap
    logic [7:0]   m_d;

    task automatic model_reset();
        q.delete(); init_q.delete();
        m_ptr_b = 0; m_err = 0; m_mode = 0; m_low = 0; m_gap = 0; m_d = 0; m_cur_init = 0;
`ifdef PSG_MUTE_INIT_EN
        init_q = '{8'h9F, 8'hBF, 8'hDF, 8'hFF};
        m_init_pend = 1;
`else
        m_init_pend = 0;
`endif
    endtask

    function automatic bit exp_a();
        bit room = !RST && (q.size() < DEPTH) && !m_init_pend;
        return room && a_valid && (!b_valid || !m_ptr_b);
    endfunction

    function automatic bit exp_b();
        bit room = !RST && (q.size() < DEPTH) && !m_init_pend;
        return room && b_valid && (!a_valid || m_ptr_b);
    endfunction

    task automatic model_step();
        bit ga, gb;
        ga = exp_a(); gb = exp_b();
        case (m_mode)
            0: begin
                if (init_q.size() > 0) begin
                    m_d = init_q.pop_front(); m_cur_init = 1; m_mode = 1; m_low = 1;
                end else if (!m_init_pend && q.size() > 0) begin
                    m_d = q.pop_front(); m_mode = 1; m_low = 1;
                end
            end
            1: begin
                if (m_low >= 2 && psg_READY) begin
                    m_mode = 2; m_gap = 1;
                end else if (m_low == TIMEOUT) begin
                    m_mode = 2; m_gap = 1; m_err = 1;
                end else m_low++;
            end
            default: begin
                if (m_gap == GAP) begin
                    m_mode = 0;
                    if (m_cur_init && init_q.size() == 0) m_init_pend = 0;
                    m_cur_init = 0;
                end else m_gap++;
            end
        endcase
        if (ga) q.push_back(a_data);
        else if (gb) q.push_back(b_data);
        if (a_valid && b_valid && (ga || gb)) m_ptr_b = !m_ptr_b;
    endtask

    int           cyc = 0, low_cycles = 0;
    logic         prev_nce = 1, seen_ar = 0;
    byte unsigned log_d[$];
    int           log_t[$];

    task automatic check_outputs();
        chk("a_ready", a_ready, exp_a());
        chk("b_ready", b_ready, exp_b());
        chk("nCE", psg_nCE, (m_mode == 1) ? 0 : 1);
        chk("nWE", psg_nWE, (m_mode == 1) ? 0 : 1);
        chk("D", psg_D, m_d);
        chk("level", fifo_level, q.size());
        chk("busy", busy, (q.size() > 0 || m_mode != 0 || m_init_pend) ? 1 : 0);
        chk("timeout_err", timeout_err, m_err);
    endtask

    // Called just after a rising edge with inputs already driven
    task automatic cycle();
        #3;
        check_outputs();
        seen_ar = a_ready;
        if (!psg_nCE) low_cycles++;
        if (!psg_nCE && prev_nce) begin
            log_d.push_back(psg_D);
            log_t.push_back(cyc);
        end
        prev_nce = psg_nCE;
        @(posedge CLK);
        if (RST) model_reset(); else model_step();
        cyc++;
        #1;
    endtask

    task automatic push_a_until(input logic [7:0] d, input int budget);
        a_valid = 1; a_data = d;
        for (int k = 0; k < budget && a_valid; k++) begin
            cycle();
            if (seen_ar) a_valid = 0;
        end
        if (a_valid) begin
            chk("push_timeout", 0, 1);
            a_valid = 0;
        end
    endtask

    initial begin
        byte unsigned exp_l[$];
        int ai, bi, n;

        model_reset();
        #1 RST = 1;
        #1;
        chk("rst_nCE", psg_nCE, 1);
        chk("rst_nWE", psg_nWE, 1);
        chk("rst_D", psg_D, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_ar", a_ready, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        // A requests from the first cycle after reset
        a_valid = 1; a_data = 8'h55;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (seen_ar) a_valid = 0;
        end
`ifdef PSG_MUTE_INIT_EN
        exp_l = '{8'h9F, 8'hBF, 8'hDF, 8'hFF, 8'h55};
`else
        exp_l = '{8'h55};
`endif
        chk("init_count", log_d.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < log_d.size(); i++) chk("init_order", log_d[i], exp_l[i]);
        log_d.delete(); log_t.delete();

        // Both requesters contend, READY tied high
        psg_READY = 1; ai = 0; bi = 0;
        for (int k = 0; k < 60; k++) begin
            a_valid = (ai < 4); a_data = 8'h10 + 8'(ai);
            b_valid = (bi < 4); b_data = 8'h20 + 8'(bi);
            #3;
            if (a_valid && a_ready) ai++;
            if (b_valid && b_ready) bi++;
            #(-0);
            cycle();
        end
        a_valid = 0; b_valid = 0;
        exp_l = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        chk("rr_count", log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) chk("rr_order", log_d[i], exp_l[i]);
        for (int i = 1; i < 8 && i < log_t.size(); i++) chk("rr_spacing", log_t[i] - log_t[i-1], 3 + GAP);
        log_d.delete(); log_t.delete();

        // A only, READY pulsed 5 cycles after nCE falls
        psg_READY = 0; low_cycles = 0;
        a_valid = 1; a_data = 8'h8E;
        for (int k = 0; k < 30; k++) begin
            psg_READY = (log_t.size() > 0 && cyc - log_t[0] == 5);
            cycle();
            if (seen_ar) a_valid = 0;
        end
        psg_READY = 1;
        chk("aonly_byte", (log_d.size() > 0) ? log_d[0] : 0, 8'h8E);
        chk("aonly_low", low_cycles, 6);
        chk("aonly_idle", busy, 0);
        log_d.delete(); log_t.delete();

        // Fill while READY is held low
        psg_READY = 0; n = 0;
        a_valid = 1; a_data = 8'hA0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (seen_ar) begin n++; a_data = 8'hA0 + 8'(n); end
        end
        chk("fill_level", fifo_level, DEPTH);
        chk("fill_pushed", n, 5);
        psg_READY = 1;
        for (int k = 0; k < 60; k++) begin
            a_valid = (n < 6);
            cycle();
            if (seen_ar) begin n++; a_data = 8'hA0 + 8'(n); end
        end
        a_valid = 0;
        chk("fill_count", log_d.size(), 6);
        for (int i = 0; i < 6 && i < log_d.size(); i++) chk("fill_order", log_d[i], 8'hA0 + 8'(i));
        log_d.delete(); log_t.delete();

        // Forced release
        psg_READY = 0; low_cycles = 0;
        push_a_until(8'h77, 10);
        repeat (80) cycle();
        chk("to_low", low_cycles, TIMEOUT);
        chk("to_err", timeout_err, 1);
        psg_READY = 1;
        push_a_until(8'h78, 10);
        repeat (20) cycle();
        chk("to_next", (log_d.size() > 0) ? log_d[log_d.size()-1] : 0, 8'h78);
        chk("to_sticky", timeout_err, 1);
        log_d.delete(); log_t.delete();

        // Reset in the middle of a write with bytes queued
        psg_READY = 0;
        for (int i = 0; i < 4; i++) push_a_until(8'hC0 + 8'(i), 10);
        repeat (3) cycle();
        chk("pre_rst_low", psg_nCE, 0);
        #2 RST = 1;
        #1;
        chk("mid_rst_nCE", psg_nCE, 1);
        chk("mid_rst_nWE", psg_nWE, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_err", timeout_err, 0);
        model_reset();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 0; psg_READY = 1; prev_nce = 1;
        log_d.delete(); log_t.delete();
        repeat (30) cycle();
`ifdef PSG_MUTE_INIT_EN
        chk("no_stale", log_d.size(), 4);
`else
        chk("no_stale", log_d.size(), 0);
`endif

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            a_valid   = ($urandom_range(0, 2) == 0);
            b_valid   = ($urandom_range(0, 2) == 0);
            a_data    = 8'($urandom);
            b_data    = 8'($urandom);
            psg_READY = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
